// File: rtl/params_pkg.sv
// Shared core parameters and the writeback entry type.
package params_pkg;

  localparam int unsigned REGISTER_WIDTH = 5;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned INSTR_WIDTH    = 32;

  // One pending register-file write. Debug fields travel with the data in simulation only.
  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
`ifndef SYNTHESIS
    logic [ADDR_WIDTH-1:0]     debug_pc;
    logic [INSTR_WIDTH-1:0]    debug_instr;
`endif
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is discarded.
module wb_fifo
  import params_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  wb_entry_t        data_i,
  input  logic             pop_i,
  output wb_entry_t        data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == FULL_COUNT);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and multiplier results onto one register-file write port.
// Mul results cannot stall, so they are buffered; only the ALU sees back-pressure.
module wb_arbiter
  import params_pkg::*;
#(
  parameter  int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter  int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter  int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter  int unsigned MUL_BUF_DEPTH  = 4,
  localparam int unsigned CNT_W          = $clog2(MUL_BUF_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alu_valid_i,
  input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  output logic                      alu_ready_o,
  input  logic                      mul_valid_i,
  input  logic [REGISTER_WIDTH-1:0] mul_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]     mul_result_i,
  output logic                      rf_wr_en_o,
  output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
  output logic [CNT_W-1:0]          mul_pending_o,
  output logic                      overflow_o
`ifndef SYNTHESIS
  ,
  input  logic [ADDR_WIDTH-1:0]     alu_debug_pc_i,
  input  logic [INSTR_WIDTH-1:0]    alu_debug_instr_i,
  input  logic [ADDR_WIDTH-1:0]     mul_debug_pc_i,
  input  logic [INSTR_WIDTH-1:0]    mul_debug_instr_i,
  output logic [ADDR_WIDTH-1:0]     rf_debug_pc_o,
  output logic [INSTR_WIDTH-1:0]    rf_debug_instr_o
`endif
);

  // Keeping one slot free guarantees a mul arrival always has room while the ALU wins.
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(MUL_BUF_DEPTH - 1);

  wb_entry_t        alu_entry;
  wb_entry_t        mul_entry;
  wb_entry_t        head_entry;
  wb_entry_t        grant_entry;
  logic             grant_valid;
  logic             alu_accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;

  assign alu_ready_o   = (count < READY_LIMIT);
  assign alu_accept    = alu_valid_i && alu_ready_o;
  assign mul_pending_o = count;

  // Pack each source into a writeback entry.
  always_comb begin
    alu_entry             = '0;
    alu_entry.wr_reg      = alu_wr_reg_i;
    alu_entry.data        = alu_result_i;
    mul_entry             = '0;
    mul_entry.wr_reg      = mul_wr_reg_i;
    mul_entry.data        = mul_result_i;
`ifndef SYNTHESIS
    alu_entry.debug_pc    = alu_debug_pc_i;
    alu_entry.debug_instr = alu_debug_instr_i;
    mul_entry.debug_pc    = mul_debug_pc_i;
    mul_entry.debug_instr = mul_debug_instr_i;
`endif
  end

  // Fixed priority: accepted ALU, then buffered mul (older), then bypassed mul.
  always_comb begin
    grant_valid = 1'b0;
    grant_entry = alu_entry;
    push        = 1'b0;
    pop         = 1'b0;
    if (alu_accept) begin
      grant_valid = 1'b1;
      grant_entry = alu_entry;
      push        = mul_valid_i;
    end else if (!fifo_empty) begin
      grant_valid = 1'b1;
      grant_entry = head_entry;
      pop         = 1'b1;
      push        = mul_valid_i;
    end else if (mul_valid_i) begin
      grant_valid = 1'b1;
      grant_entry = mul_entry;
    end
  end

  wb_fifo #(
    .DEPTH (MUL_BUF_DEPTH)
  ) u_mul_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (mul_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Register the winning entry onto the write port; write data is don't-care under reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_wr_en_o <= 1'b0;
    end else begin
      rf_wr_en_o <= grant_valid;
    end
    rf_wr_reg_o      <= grant_entry.wr_reg;
    rf_wr_data_o     <= grant_entry.data;
`ifndef SYNTHESIS
    rf_debug_pc_o    <= grant_entry.debug_pc;
    rf_debug_instr_o <= grant_entry.debug_instr;
`endif
  end

  // Sticky flag for a mul result dropped because the buffer was full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (DEPTH = 4).
module tb_wb_arbiter;
  import params_pkg::*;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_wr_reg;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        mul_valid;
  logic [4:0]  mul_wr_reg;
  logic [31:0] mul_result;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic [2:0]  mul_pending;
  logic        overflow;
`ifndef SYNTHESIS
  logic [31:0] alu_dpc, alu_dins, mul_dpc, mul_dins, rf_dpc, rf_dins;
`endif

  int unsigned applied;
  int unsigned miscompares;

  wb_arbiter #(
    .MUL_BUF_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alu_valid_i   (alu_valid),
    .alu_wr_reg_i  (alu_wr_reg),
    .alu_result_i  (alu_result),
    .alu_ready_o   (alu_ready),
    .mul_valid_i   (mul_valid),
    .mul_wr_reg_i  (mul_wr_reg),
    .mul_result_i  (mul_result),
    .rf_wr_en_o    (rf_wr_en),
    .rf_wr_reg_o   (rf_wr_reg),
    .rf_wr_data_o  (rf_wr_data),
    .mul_pending_o (mul_pending),
    .overflow_o    (overflow)
`ifndef SYNTHESIS
    ,
    .alu_debug_pc_i    (alu_dpc),
    .alu_debug_instr_i (alu_dins),
    .mul_debug_pc_i    (mul_dpc),
    .mul_debug_instr_i (mul_dins),
    .rf_debug_pc_o     (rf_dpc),
    .rf_debug_instr_o  (rf_dins)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [2:0]  e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic e_rdy, logic e_we, logic [4:0] e_reg,
                              logic [31:0] e_data, logic [2:0] e_pend);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_reg = e_reg;
    v.e_data = e_data; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Debug PC/instr are derived from data so the write-port copy can be predicted.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_wr_reg = ar; alu_result = ad;
    mul_valid = mv; mul_wr_reg = mr; mul_result = md;
`ifndef SYNTHESIS
    alu_dpc = ad ^ 32'h1000_0000; alu_dins = ~ad;
    mul_dpc = md ^ 32'h1000_0000; mul_dins = ~md;
`endif
  endtask

  // Drive one cycle of inputs, check ready before the edge and the write port after it.
  task automatic apply(input vec_t v, input int unsigned idx);
    drive(v.av, v.ar, v.ad, v.mv, v.mr, v.md);
    #1;
    chk($sformatf("v%0d alu_ready", idx), 32'(alu_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rf_wr_en", idx), 32'(rf_wr_en), 32'(v.e_we));
    if (v.e_we) begin
      chk($sformatf("v%0d rf_wr_reg", idx), 32'(rf_wr_reg), 32'(v.e_reg));
      chk($sformatf("v%0d rf_wr_data", idx), rf_wr_data, v.e_data);
`ifndef SYNTHESIS
      chk($sformatf("v%0d rf_debug_pc", idx), rf_dpc, v.e_data ^ 32'h1000_0000);
      chk($sformatf("v%0d rf_debug_instr", idx), rf_dins, ~v.e_data);
`endif
    end
    chk($sformatf("v%0d mul_pending", idx), 32'(mul_pending), 32'(v.e_pend));
    chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'd0);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // ---- Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("reset alu_ready", 32'(alu_ready), 32'd1);
    chk("reset mul_pending", 32'(mul_pending), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);

    // ---- Vector table
    // ALU only, then back-to-back ALU, then a write to r0 forwarded unchanged
    vecs.push_back(mk(1, 5'd3, 32'h11, 0, 0, 0,   1, 1, 5'd3, 32'h11, 3'd0));
    vecs.push_back(mk(1, 5'd4, 32'h22, 0, 0, 0,   1, 1, 5'd4, 32'h22, 3'd0));
    vecs.push_back(mk(1, 5'd5, 32'h33, 0, 0, 0,   1, 1, 5'd5, 32'h33, 3'd0));
    vecs.push_back(mk(1, 5'd0, 32'h55, 0, 0, 0,   1, 1, 5'd0, 32'h55, 3'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 0, 5'd0, 32'h0, 3'd0));
    // Collision: ALU first, mul one cycle later via the buffer
    vecs.push_back(mk(1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 1, 5'd1, 32'hA, 3'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 1, 5'd2, 32'hB, 3'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 0, 5'd0, 32'h0, 3'd0));
    // Mul-only stream: bypass path, buffer stays empty
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 0, 0, 1, 5'(6 + k), 32'h60 + 32'(k),
                        1, 1, 5'(6 + k), 32'h60 + 32'(k), 3'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 0, 5'd0, 32'h0, 3'd0));
    // Saturation: 5 ALU + 5 mul; ALU holds its result while not ready
    vecs.push_back(mk(1, 5'd16, 32'hA0, 1, 5'd24, 32'hB0, 1, 1, 5'd16, 32'hA0, 3'd1));
    vecs.push_back(mk(1, 5'd17, 32'hA1, 1, 5'd25, 32'hB1, 1, 1, 5'd17, 32'hA1, 3'd2));
    vecs.push_back(mk(1, 5'd18, 32'hA2, 1, 5'd26, 32'hB2, 1, 1, 5'd18, 32'hA2, 3'd3));
    vecs.push_back(mk(1, 5'd19, 32'hA3, 1, 5'd27, 32'hB3, 0, 1, 5'd24, 32'hB0, 3'd3));
    vecs.push_back(mk(1, 5'd19, 32'hA3, 1, 5'd28, 32'hB4, 0, 1, 5'd25, 32'hB1, 3'd3));
    vecs.push_back(mk(1, 5'd19, 32'hA3, 0, 0, 0,           0, 1, 5'd26, 32'hB2, 3'd2));
    vecs.push_back(mk(1, 5'd19, 32'hA3, 0, 0, 0,           1, 1, 5'd19, 32'hA3, 3'd2));
    vecs.push_back(mk(1, 5'd20, 32'hA4, 0, 0, 0,           1, 1, 5'd20, 32'hA4, 3'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 1, 5'd27, 32'hB3, 3'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 1, 5'd28, 32'hB4, 3'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 0, 5'd0, 32'h0, 3'd0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // ---- Reset with two buffered mul results: contents discarded, no stale write
    drive(1, 5'd7, 32'hC0, 1, 5'd8, 32'hD0);
    @(posedge clk); #1;
    drive(1, 5'd9, 32'hC1, 1, 5'd10, 32'hD1);
    @(posedge clk); #1;
    chk("pre-reset mul_pending", 32'(mul_pending), 32'd2);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-reset mul_pending", 32'(mul_pending), 32'd0);
    chk("mid-reset rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("mid-reset alu_ready", 32'(alu_ready), 32'd1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset c%0d rf_wr_en", c), 32'(rf_wr_en), 32'd0);
      chk($sformatf("post-reset c%0d mul_pending", c), 32'(mul_pending), 32'd0);
      chk($sformatf("post-reset c%0d overflow", c), 32'(overflow), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
